// File: rtl/debug_cmd_engine_if.sv
// UART word-bridge and shared memory-bus signals of the debug command engine.
// master = engine side, slave = UART bridge / memory side.
interface debug_cmd_engine_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  uart_rx_empty;
   logic                  uart_read;
   logic                  uart_read_response;
   logic [31:0]           uart_read_data;
   logic                  uart_write;
   logic                  uart_write_response;
   logic [31:0]           uart_write_data;
   logic                  memory_mux_selector;
   logic                  memory_read;
   logic                  memory_write;
   logic                  memory_response;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;

   modport master (
      input  uart_rx_empty, uart_read_response, uart_read_data, uart_write_response,
             memory_response, read_data,
      output uart_read, uart_write, uart_write_data, memory_mux_selector,
             memory_read, memory_write, address, write_data
   );

   modport slave (
      output uart_rx_empty, uart_read_response, uart_read_data, uart_write_response,
             memory_response, read_data,
      input  uart_read, uart_write, uart_write_data, memory_mux_selector,
             memory_read, memory_write, address, write_data
   );
endinterface

// File: rtl/debug_cmd_engine.sv
// Host command interpreter: UART command words drive core clock/reset gating and memory accesses.
// Optional ACC_AUTO_INC_EN: successful 's'/'a' accesses advance the accumulator by one data word.
module debug_cmd_engine #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned PULSE_BITS      = 32,
   parameter logic [31:0] ID              = 32'h7700006A,
   parameter int unsigned RESET_CYCLES    = 20,
   parameter int unsigned TIMEOUT_DEFAULT = 360,
   parameter logic [31:0] ERR_WORD        = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  reset,
   debug_cmd_engine_if.master    bus,
   output logic                  core_clk_enable,
   output logic                  core_reset,
   output logic [PULSE_BITS-1:0] cycles_to_pulse,
   output logic                  write_pulse,
   output logic                  busy
);
   localparam logic [7:0] OP_PULSE  = 8'h43; // 'C'
   localparam logic [7:0] OP_STOP   = 8'h53; // 'S'
   localparam logic [7:0] OP_GO     = 8'h47; // 'G'
   localparam logic [7:0] OP_RESET  = 8'h52; // 'R'
   localparam logic [7:0] OP_ACC_HI = 8'h55; // 'U'
   localparam logic [7:0] OP_ACC_LO = 8'h6C; // 'l'
   localparam logic [7:0] OP_ADD    = 8'h41; // 'A'
   localparam logic [7:0] OP_TMO    = 8'h54; // 'T'
   localparam logic [7:0] OP_PING   = 8'h70; // 'p'
   localparam logic [7:0] OP_WRITE  = 8'h57; // 'W'
   localparam logic [7:0] OP_LOAD   = 8'h4C; // 'L'
   localparam logic [7:0] OP_ST_ACC = 8'h73; // 's'
   localparam logic [7:0] OP_LD_ACC = 8'h61; // 'a'

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC, FETCH2, MEM_WAIT, RST_HOLD, SEND, SEND_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           cmd_q, cmd_d;
   logic [ADDR_WIDTH-1:0] acc_q, acc_d;
   logic [23:0]           timeout_q, timeout_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [31:0]           reply_q, reply_d;
   logic                  uart_read_q, uart_read_d;
   logic                  uart_write_q, uart_write_d;
   logic [31:0]           uart_write_data_q, uart_write_data_d;
   logic                  core_clk_enable_q, core_clk_enable_d;
   logic                  core_reset_q, core_reset_d;
   logic [PULSE_BITS-1:0] cycles_to_pulse_q, cycles_to_pulse_d;
   logic                  write_pulse_q, write_pulse_d;
   logic                  mux_q, mux_d;
   logic                  memory_read_q, memory_read_d;
   logic                  memory_write_q, memory_write_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
   logic                  busy_q, busy_d;

   logic [7:0]            opcode;
   logic [23:0]           imm;
   logic [ADDR_WIDTH-1:0] n_addr;

   assign opcode = cmd_q[7:0];
   assign imm    = cmd_q[31:8];
   assign n_addr = ADDR_WIDTH'(imm);

   always_comb begin
      state_d           = state_q;
      cmd_d             = cmd_q;
      acc_d             = acc_q;
      timeout_d         = timeout_q;
      cnt_d             = cnt_q;
      reply_d           = reply_q;
      uart_read_d       = uart_read_q;
      uart_write_d      = uart_write_q;
      uart_write_data_d = uart_write_data_q;
      core_clk_enable_d = core_clk_enable_q;
      core_reset_d      = core_reset_q;
      cycles_to_pulse_d = cycles_to_pulse_q;
      write_pulse_d     = 1'b0;
      mux_d             = mux_q;
      memory_read_d     = memory_read_q;
      memory_write_d    = memory_write_q;
      address_d         = address_q;
      write_data_d      = write_data_q;

      case (state_q)
         IDLE: begin
            if (!bus.uart_rx_empty) begin
               uart_read_d = 1'b1;
               state_d     = FETCH;
            end
         end
         FETCH: begin
            if (bus.uart_read_response) begin
               cmd_d       = bus.uart_read_data;
               uart_read_d = 1'b0;
               state_d     = DECODE;
            end
         end
         DECODE: begin
            // Bus ownership, address and data are set on the same edge the request rises.
            case (opcode)
               OP_WRITE: begin
                  uart_read_d = 1'b1;
                  state_d     = FETCH2;
               end
               OP_RESET: begin
                  core_reset_d = 1'b1;
                  cnt_d        = '0;
                  state_d      = RST_HOLD;
               end
               OP_LOAD: begin
                  mux_d         = 1'b0;
                  memory_read_d = 1'b1;
                  address_d     = n_addr;
                  cnt_d         = '0;
                  state_d       = MEM_WAIT;
               end
               OP_ST_ACC: begin
                  mux_d          = 1'b0;
                  memory_write_d = 1'b1;
                  address_d      = acc_q;
                  write_data_d   = DATA_WIDTH'(imm);
                  cnt_d          = '0;
                  state_d        = MEM_WAIT;
               end
               OP_LD_ACC: begin
                  mux_d         = 1'b0;
                  memory_read_d = 1'b1;
                  address_d     = acc_q;
                  cnt_d         = '0;
                  state_d       = MEM_WAIT;
               end
               default: state_d = EXEC;
            endcase
         end
         EXEC: begin
            state_d = IDLE;
            case (opcode)
               OP_PULSE: begin
                  cycles_to_pulse_d = PULSE_BITS'(imm);
                  write_pulse_d     = 1'b1;
                  mux_d             = 1'b1;
               end
               OP_STOP:   core_clk_enable_d = 1'b0;
               OP_GO: begin
                  core_clk_enable_d = 1'b1;
                  mux_d             = 1'b1;
               end
               OP_ACC_HI: acc_d = (n_addr << 8) | {{(ADDR_WIDTH-8){1'b0}}, acc_q[7:0]};
               OP_ACC_LO: acc_d[7:0] = imm[7:0];
               OP_ADD:    acc_d = acc_q + n_addr;
               OP_TMO:    timeout_d = imm;
               OP_PING: begin
                  reply_d = ID;
                  state_d = SEND;
               end
               default: begin
                  reply_d = ERR_WORD;
                  state_d = SEND;
               end
            endcase
         end
         FETCH2: begin
            if (bus.uart_read_response) begin
               uart_read_d    = 1'b0;
               mux_d          = 1'b0;
               memory_write_d = 1'b1;
               address_d      = n_addr;
               write_data_d   = DATA_WIDTH'(bus.uart_read_data);
               cnt_d          = '0;
               state_d        = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            // A response arriving on the expiry cycle still wins over the timeout.
            if (bus.memory_response) begin
               memory_read_d  = 1'b0;
               memory_write_d = 1'b0;
               if (memory_read_q) begin
                  reply_d = 32'(bus.read_data);
                  state_d = SEND;
               end else begin
                  state_d = IDLE;
               end
`ifdef ACC_AUTO_INC_EN
               if (opcode == OP_ST_ACC || opcode == OP_LD_ACC)
                  acc_d = acc_q + ADDR_WIDTH'(DATA_WIDTH / 8);
`endif
            end else if (timeout_q != '0 && cnt_q + 32'd1 == 32'(timeout_q)) begin
               memory_read_d  = 1'b0;
               memory_write_d = 1'b0;
               reply_d        = ERR_WORD;
               state_d        = SEND;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RST_HOLD: begin
            if (cnt_q == 32'(RESET_CYCLES - 1)) begin
               core_reset_d = 1'b0;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         SEND: begin
            uart_write_data_d = reply_q;
            uart_write_d      = 1'b1;
            state_d           = SEND_WAIT;
         end
         SEND_WAIT: begin
            if (bus.uart_write_response) begin
               uart_write_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= IDLE;
         cmd_q             <= '0;
         acc_q             <= '0;
         timeout_q         <= 24'(TIMEOUT_DEFAULT);
         cnt_q             <= '0;
         reply_q           <= '0;
         uart_read_q       <= 1'b0;
         uart_write_q      <= 1'b0;
         uart_write_data_q <= '0;
         core_clk_enable_q <= 1'b0;
         core_reset_q      <= 1'b0;
         cycles_to_pulse_q <= '0;
         write_pulse_q     <= 1'b0;
         mux_q             <= 1'b0;
         memory_read_q     <= 1'b0;
         memory_write_q    <= 1'b0;
         address_q         <= '0;
         write_data_q      <= '0;
         busy_q            <= 1'b0;
      end else begin
         state_q           <= state_d;
         cmd_q             <= cmd_d;
         acc_q             <= acc_d;
         timeout_q         <= timeout_d;
         cnt_q             <= cnt_d;
         reply_q           <= reply_d;
         uart_read_q       <= uart_read_d;
         uart_write_q      <= uart_write_d;
         uart_write_data_q <= uart_write_data_d;
         core_clk_enable_q <= core_clk_enable_d;
         core_reset_q      <= core_reset_d;
         cycles_to_pulse_q <= cycles_to_pulse_d;
         write_pulse_q     <= write_pulse_d;
         mux_q             <= mux_d;
         memory_read_q     <= memory_read_d;
         memory_write_q    <= memory_write_d;
         address_q         <= address_d;
         write_data_q      <= write_data_d;
         busy_q            <= busy_d;
      end
   end

   assign bus.uart_read           = uart_read_q;
   assign bus.uart_write          = uart_write_q;
   assign bus.uart_write_data     = uart_write_data_q;
   assign bus.memory_mux_selector = mux_q;
   assign bus.memory_read         = memory_read_q;
   assign bus.memory_write        = memory_write_q;
   assign bus.address             = address_q;
   assign bus.write_data          = write_data_q;
   assign core_clk_enable         = core_clk_enable_q;
   assign core_reset              = core_reset_q;
   assign cycles_to_pulse         = cycles_to_pulse_q;
   assign write_pulse             = write_pulse_q;
   assign busy                    = busy_q;
endmodule

// File: tb/tb_debug_cmd_engine.sv
// Scoreboard bench for debug_cmd_engine: stimulus queues expected replies, memory accesses and pulses;
// UART, memory and strobe monitors pop and compare as the engine presents them.
module tb_debug_cmd_engine;
   logic        clk;
   logic        reset;
   logic        core_clk_enable;
   logic        core_reset;
   logic [31:0] cycles_to_pulse;
   logic        write_pulse;
   logic        busy;

   debug_cmd_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   debug_cmd_engine #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .PULSE_BITS(32), .ID(32'h7700006A),
      .RESET_CYCLES(20), .TIMEOUT_DEFAULT(360), .ERR_WORD(32'hDEADBEEF)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .core_clk_enable(core_clk_enable), .core_reset(core_reset),
      .cycles_to_pulse(cycles_to_pulse), .write_pulse(write_pulse), .busy(busy)
   );

   typedef struct { logic [31:0] word; int unsigned lat; } reply_t;
   typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; int unsigned len; } mem_t;

   reply_t      exp_reply[$];
   mem_t        exp_mem[$];
   logic [31:0] exp_pulse[$];
   logic [31:0] rx_q[$];
   logic [31:0] mem[logic [31:0]];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;
   int unsigned fetch_cyc = 0;
   int unsigned mem_delay = 2;
   int unsigned cur_len   = 0;
   int unsigned rst_runs  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever @(posedge clk) cyc++;

   // UART receive side: hands out queued command words immediately on request.
   initial begin
      bus.uart_rx_empty      = 1'b1;
      bus.uart_read_response = 1'b0;
      bus.uart_read_data     = '0;
      forever @(negedge clk) begin
         bus.uart_read_response = 1'b0;
         if (bus.uart_read === 1'b1 && rx_q.size() != 0) begin
            bus.uart_read_response = 1'b1;
            bus.uart_read_data     = rx_q.pop_front();
            fetch_cyc              = cyc;
         end
         bus.uart_rx_empty = (rx_q.size() == 0);
      end
   end

   // UART transmit side: checks each reply, acknowledges it on the third cycle.
   initial begin
      int unsigned wcnt;
      logic        acked;
      reply_t      r;
      wcnt = 0;
      acked = 1'b0;
      bus.uart_write_response = 1'b0;
      forever @(negedge clk) begin
         bus.uart_write_response = 1'b0;
         if (bus.uart_write === 1'b1) begin
            wcnt++;
            if (wcnt == 1) begin
               acked = 1'b0;
               if (exp_reply.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_reply: got 0x%0h, expected none", bus.uart_write_data);
               end else begin
                  r = exp_reply.pop_front();
                  check("reply_word", bus.uart_write_data, r.word);
                  if (r.lat != 0) check("reply_latency", cyc - fetch_cyc, r.lat);
               end
            end
            if (wcnt == 3) begin
               bus.uart_write_response = 1'b1;
               acked = 1'b1;
            end
            if (wcnt == 4) check("uart_write_drop", bus.uart_write, 0);
         end else begin
            if (wcnt != 0) check("uart_write_held", acked, 1);
            wcnt = 0;
         end
      end
   end

   // Memory side: checks each request, answers after mem_delay cycles (0 = never).
   initial begin
      int unsigned mcnt;
      mem_t        e;
      mcnt = 0;
      bus.memory_response = 1'b0;
      bus.read_data       = '0;
      forever @(negedge clk) begin
         bus.memory_response = 1'b0;
         if (bus.memory_read === 1'b1 || bus.memory_write === 1'b1) begin
            mcnt++;
            if (mcnt == 1) begin
               if (exp_mem.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_access: got addr 0x%0h, expected none", bus.address);
                  cur_len = 0;
               end else begin
                  e = exp_mem.pop_front();
                  cur_len = e.len;
                  check("mem_kind", {bus.memory_write, bus.memory_read}, e.wr ? 2'b10 : 2'b01);
                  check("mem_addr", bus.address, e.addr);
                  check("mem_mux", bus.memory_mux_selector, 0);
                  if (e.wr) check("mem_wdata", bus.write_data, e.data);
               end
            end
            if (mem_delay != 0 && mcnt == mem_delay) begin
               bus.memory_response = 1'b1;
               if (bus.memory_write === 1'b1) mem[bus.address] = bus.write_data;
               else bus.read_data = mem.exists(bus.address) ? mem[bus.address]
                                                            : (32'hA5000000 | bus.address);
            end
         end else begin
            if (mcnt != 0 && cur_len != 0) check("mem_req_len", mcnt, cur_len);
            mcnt = 0;
         end
      end
   end

   // Strobe monitors: core_reset run length and write_pulse width/value.
   initial begin
      int unsigned rlen, plen;
      rlen = 0;
      plen = 0;
      forever @(negedge clk) begin
         if (core_reset === 1'b1) rlen++;
         else begin
            if (rlen != 0) begin
               check("core_reset_len", rlen, 20);
               rst_runs++;
            end
            rlen = 0;
         end
         if (write_pulse === 1'b1) begin
            plen++;
            if (plen == 1) begin
               if (exp_pulse.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_pulse: got %0d, expected none", cycles_to_pulse);
               end else check("cycles_to_pulse", cycles_to_pulse, exp_pulse.pop_front());
            end
         end else begin
            if (plen != 0) check("write_pulse_width", plen, 1);
            plen = 0;
         end
      end
   end

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy === 1'b1) seen = 1'b1;
         else if (seen && rx_q.size() == 0) begin
            repeat (2) @(negedge clk);
            return;
         end
      end
      n_checks++;
      $display("FAIL cmd_complete: engine still busy after 300 cycles, expected idle");
   endtask

   task automatic send(input logic [31:0] w);
      rx_q.push_back(w);
      wait_done();
   endtask

   task automatic send2(input logic [31:0] w0, input logic [31:0] w1);
      rx_q.push_back(w0);
      rx_q.push_back(w1);
      wait_done();
   endtask

   task automatic exp_r(input logic [31:0] w, input int unsigned lat);
      reply_t r;
      r.word = w;
      r.lat  = lat;
      exp_reply.push_back(r);
   endtask

   task automatic exp_m(input logic wr, input logic [31:0] a, input logic [31:0] d, input int unsigned len);
      mem_t e;
      e.wr = wr; e.addr = a; e.data = d; e.len = len;
      exp_mem.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_uart_read"},  bus.uart_read, 0);
      check({tag, "_uart_write"}, bus.uart_write, 0);
      check({tag, "_uart_wdata"}, bus.uart_write_data, 0);
      check({tag, "_mux"},        bus.memory_mux_selector, 0);
      check({tag, "_mem_rw"},     {bus.memory_read, bus.memory_write}, 0);
      check({tag, "_addr"},       bus.address, 0);
      check({tag, "_wdata"},      bus.write_data, 0);
      check({tag, "_clk_en"},     core_clk_enable, 0);
      check({tag, "_core_rst"},   core_reset, 0);
      check({tag, "_pulse"},      {write_pulse, cycles_to_pulse}, 0);
      check({tag, "_busy"},       busy, 0);
   endtask

   initial begin
      logic found;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Ping with immediate handshakes: ID, 4-cycle latency.
      exp_r(32'h7700006A, 4);
      send(32'h00000070);

      // 'W' then 'L' round trip at 0x100.
      exp_m(1'b1, 32'h100, 32'hCAFEF00D, 2);
      send2(32'h00010057, 32'hCAFEF00D);
      exp_m(1'b0, 32'h100, 32'h0, 2);
      exp_r(32'hCAFEF00D, 0);
      send(32'h0001004C);
      check("mux_after_mem", bus.memory_mux_selector, 0);

      // Accumulator build-up to 0x10C, store, then read back through acc.
      send(32'h00000155);
      send(32'h0000046C);
      send(32'h00000841);
      exp_m(1'b1, 32'h10C, 32'h55, 2);
      send(32'h00005573);
`ifdef ACC_AUTO_INC_EN
      exp_m(1'b0, 32'h110, 32'h0, 2);
      exp_r(32'hA5000110, 0);
`else
      exp_m(1'b0, 32'h10C, 32'h0, 2);
      exp_r(32'h00000055, 0);
`endif
      send(32'h00000061);

      // Accumulator wrap: 0xFFFFFFFF + 2 = 1.
      send(32'hFFFFFF55);
      send(32'h0000FF6C);
      send(32'h00000241);
      exp_m(1'b1, 32'h1, 32'h7, 2);
      send(32'h00000773);

      // Timeout 5 with no response.
      send(32'h00000554);
      mem_delay = 0;
      exp_m(1'b0, 32'h100, 32'h0, 5);
      exp_r(32'hDEADBEEF, 0);
      send(32'h0001004C);

      // Timeout 3: response on the expiry cycle succeeds, one cycle later fails.
      send(32'h00000354);
      mem_delay = 3;
      exp_m(1'b0, 32'h100, 32'h0, 3);
      exp_r(32'hCAFEF00D, 0);
      send(32'h0001004C);
      mem_delay = 4;
      exp_m(1'b0, 32'h100, 32'h0, 3);
      exp_r(32'hDEADBEEF, 0);
      send(32'h0001004C);

      // Write timeout replies the error word and leaves memory untouched.
      send(32'h00000254);
      mem_delay = 0;
      exp_m(1'b1, 32'h200, 32'h12345678, 2);
      exp_r(32'hDEADBEEF, 0);
      send2(32'h00020057, 32'h12345678);
      mem_delay = 2;
      exp_m(1'b0, 32'h200, 32'h0, 2);
      exp_r(32'hA5000200, 0);
      send(32'h0002004C);

      // Core reset, pulse, clock gate.
      send(32'h00000052);
      check("core_reset_runs", rst_runs, 1);
      exp_pulse.push_back(32'd16);
      send(32'h00001043);
      check("mux_after_pulse", bus.memory_mux_selector, 1);
      send(32'h00000047);
      check("clk_en_go", core_clk_enable, 1);
      send(32'h00000053);
      check("clk_en_stop", core_clk_enable, 0);

      // Unknown opcode.
      exp_r(32'hDEADBEEF, 0);
      send(32'h0000007A);

      // Reset while waiting on a stalled read.
      mem_delay = 0;
      exp_m(1'b0, 32'h300, 32'h0, 0);
      rx_q.push_back(32'h0003004C);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (bus.memory_read === 1'b1) found = 1'b1;
      end
      check("stall_read_seen", bus.memory_read, 1);
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("midop_reset");
      reset = 1'b0;
      mem_delay = 2;
      exp_r(32'h7700006A, 4);
      send(32'h00000070);

      check("replies_left", exp_reply.size(), 0);
      check("accesses_left", exp_mem.size(), 0);
      check("pulses_left", exp_pulse.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
